no_1s_gen: RTL and testbench
============================

Name: no_1s_gen

Overview:
- Inverse of the ones-counter: takes a target ones count and a 16-bit placement mask and builds a word with exactly that many ones.
- Ones are placed on the lowest-indexed set bits of the mask, one bit position per clock.
- Output is both a serial bitstream (LSB first) and a parallel word, with a start/busy/finish handshake.
- Sits upstream of the counter as a stimulus/pattern source. Feeding its o_a back into the counter must return i_count.

Parameters:
- WIDTH, 16: word width, and the number of scan cycles per job.
- CW, 5: width of count ports, equal to clog2(WIDTH+1). Must hold the value WIDTH.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a job. Sampled only when busy=0.
- i_count  input  CW  target number of ones, 0..WIDTH valid.
- i_mask  input  WIDTH  allowed bit positions.
- o_a  output  WIDTH  generated word.
- o_bit  output  1  serial bit for the current scan position.
- o_bit_valid  output  1  o_bit qualifier, high one cycle per scanned position.
- o_placed  output  CW  running count of ones placed.
- busy  output  1  job in progress.
- finish  output  1  one-cycle pulse at job end.
- error  output  1  set with finish when request was impossible. Cleared on next accept.

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, idx=0, latched count/mask = 0.
- States: IDLE, SCAN.
- Accept (IDLE, start=1 at edge k):
  - Latch i_count and i_mask; clear o_a, o_placed and error to 0; idx=0.
  - If i_count > WIDTH: no scan. After edge k, error=1, finish=1 for one cycle, busy stays 0, state stays IDLE.
  - Else: busy=1 after edge k, go to SCAN.
- SCAN, edges k+1..k+WIDTH, processing idx = 0..WIDTH-1:
  - b = mask[idx] AND (o_placed < count).
  - o_a[idx] <= b; o_bit <= b; o_bit_valid <= 1; o_placed += b; idx += 1.
- Last position: the edge processing idx=WIDTH-1 also sets finish=1, busy=0 and returns to IDLE.
  - Fixed latency: finish high in the cycle after edge k+WIDTH (16 cycles after accept), independent of count or mask.
- At job end, if o_placed < count (mask has fewer ones than requested), error=1 with finish. o_a still holds all ones that could be placed.
- o_bit_valid and finish are single-cycle; both 0 in IDLE except as above.
- o_a, o_placed and error hold after finish until the next accept.
- start while busy=1: ignored, with no effect on the running job.
- start in the finish cycle: accepted, since state is IDLE. The new job begins, finish drops next cycle, and o_a is cleared.
- i_count/i_mask changes during SCAN: no effect; the latched values are used.
- count=0: full 16-cycle scan, all o_bit=0, o_a=0, error=0.
- Reset mid-SCAN: immediate return to reset values. No finish is issued for the aborted job.
- Arithmetic: o_placed never exceeds count, so no overflow in CW bits; the comparison is unsigned.

Test Plan:
- Reset with reset=0 mid-scan, then release -> all outputs 0, busy=0. No finish pulse for the aborted job.
- i_count=5, i_mask=16'hFFFF, start one cycle -> 16 o_bit_valid pulses carrying 1,1,1,1,1,0…0. Then finish=1 with o_a=16'h001F, o_placed=5, error=0, 16 cycles after accept.
- i_count=3, i_mask=16'hA0A0 -> o_a=16'h20A0, o_placed=3, error=0. Serial stream has ones at idx 5, 7, 13.
- i_count=6, i_mask=16'h000F -> o_a=16'h000F, o_placed=4, error=1 with finish.
- i_count=17 -> finish=1 and error=1 one cycle after accept, busy never asserts, o_a=0. Then i_count=16, i_mask=16'hFFFF -> o_a=16'hFFFF, o_placed=16, error=0.
- Held start=1 continuously with i_count=2, i_mask=16'h8001 -> back-to-back jobs. Each finish pulse is followed by a restart in the same cycle; o_a=16'h8001 at each finish. Mid-job changes to i_count are ignored.

Source files
------------

// File: rtl/no_1s_gen.sv
// Pattern generator: builds a WIDTH-bit word holding exactly i_count ones, placed on the
// lowest set bits of i_mask. It scans one bit position per clock and emits serial and parallel output.
module no_1s_gen #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CW-1:0]    i_count,
  input  logic [WIDTH-1:0] i_mask,
  output logic [WIDTH-1:0] o_a,
  output logic             o_bit,
  output logic             o_bit_valid,
  output logic [CW-1:0]    o_placed,
  output logic             busy,
  output logic             finish,
  output logic             error
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             bit_q, bit_d;
  logic             bit_valid_q, bit_valid_d;
  logic [CW-1:0]    placed_q, placed_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;
  logic             error_q, error_d;
  logic             scan_bit;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    mask_d      = mask_q;
    a_d         = a_q;
    bit_d       = 1'b0;
    bit_valid_d = 1'b0;
    placed_d    = placed_q;
    busy_d      = busy_q;
    finish_d    = 1'b0;
    error_d     = error_q;
    scan_bit    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d  = i_count;
          mask_d   = i_mask;
          a_d      = '0;
          placed_d = '0;
          idx_d    = '0;
          if (i_count > CW'(WIDTH)) begin
            // Impossible request: report immediately without scanning.
            error_d  = 1'b1;
            finish_d = 1'b1;
            busy_d   = 1'b0;
          end else begin
            error_d = 1'b0;
            busy_d  = 1'b1;
            state_d = StScan;
          end
        end
      end
      StScan: begin
        scan_bit       = mask_q[idx_q] & (placed_q < count_q);
        a_d[idx_q]     = scan_bit;
        bit_d          = scan_bit;
        bit_valid_d    = 1'b1;
        placed_d       = placed_q + CW'(scan_bit);
        idx_d          = idx_q + 1'b1;
        if (idx_q == IW'(WIDTH - 1)) begin
          finish_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
          // Mask ran out of set bits before the target was reached.
          error_d  = (placed_d < count_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      count_q     <= '0;
      mask_q      <= '0;
      a_q         <= '0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      placed_q    <= '0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      mask_q      <= mask_d;
      a_q         <= a_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      placed_q    <= placed_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      error_q     <= error_d;
    end
  end

  assign o_a         = a_q;
  assign o_bit       = bit_q;
  assign o_bit_valid = bit_valid_q;
  assign o_placed    = placed_q;
  assign busy        = busy_q;
  assign finish      = finish_q;
  assign error       = error_q;

endmodule

// File: tb/tb_no_1s_gen.sv
// Directed bench for no_1s_gen: hand-computed words, serial streams, handshake timing,
// error cases, back-to-back jobs and asynchronous reset.
module tb_no_1s_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  i_count;
  logic [15:0] i_mask;
  logic [15:0] o_a;
  logic        o_bit;
  logic        o_bit_valid;
  logic [4:0]  o_placed;
  logic        busy;
  logic        finish;
  logic        error;

  int vectors;
  int miscompares;

  no_1s_gen #(
    .WIDTH(16),
    .CW   (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .i_count    (i_count),
    .i_mask     (i_mask),
    .o_a        (o_a),
    .o_bit      (o_bit),
    .o_bit_valid(o_bit_valid),
    .o_placed   (o_placed),
    .busy       (busy),
    .finish     (finish),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_oa"}, 32'(o_a), 32'h0);
    check({tag, "_bit"}, 32'(o_bit), 32'h0);
    check({tag, "_bv"}, 32'(o_bit_valid), 32'h0);
    check({tag, "_placed"}, 32'(o_placed), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_finish"}, 32'(finish), 32'h0);
    check({tag, "_error"}, 32'(error), 32'h0);
  endtask

  // One full job; inputs are corrupted mid-scan to show the latched values are used.
  task automatic run_job(input logic [4:0] cnt, input logic [15:0] msk, input logic [15:0] exp_a,
                         input logic [4:0] exp_p, input logic exp_e, input bit poke_start);
    @(negedge clk);
    i_count = cnt;
    i_mask  = msk;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'h1);
    check("accept_finish", 32'(finish), 32'h0);
    check("accept_oa", 32'(o_a), 32'h0);
    check("accept_error", 32'(error), 32'h0);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        i_count = ~cnt;
        i_mask  = ~msk;
      end
      if (poke_start && i == 5) start = 1'b1;
      if (poke_start && i == 7) start = 1'b0;
      @(negedge clk);
      check($sformatf("bv_%0d", i), 32'(o_bit_valid), 32'h1);
      check($sformatf("bit_%0d", i), 32'(o_bit), 32'(exp_a[i]));
      if (i < 15) check($sformatf("early_finish_%0d", i), 32'(finish), 32'h0);
    end
    check("end_finish", 32'(finish), 32'h1);
    check("end_busy", 32'(busy), 32'h0);
    check("end_oa", 32'(o_a), 32'(exp_a));
    check("end_placed", 32'(o_placed), 32'(exp_p));
    check("end_error", 32'(error), 32'(exp_e));
    i_count = cnt;
    i_mask  = msk;
    @(negedge clk);
    check("post_finish", 32'(finish), 32'h0);
    check("post_bv", 32'(o_bit_valid), 32'h0);
    check("post_oa_hold", 32'(o_a), 32'(exp_a));
    check("post_placed_hold", 32'(o_placed), 32'(exp_p));
    check("post_error_hold", 32'(error), 32'(exp_e));
  endtask

  initial begin
    int seen_finish;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    start       = 1'b0;
    i_count     = '0;
    i_mask      = '0;

    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b1;

    // Reset in the middle of a scan: immediate clear, no finish afterwards.
    @(negedge clk);
    i_count = 5'd5;
    i_mask  = 16'hFFFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("midscan_busy", 32'(busy), 32'h1);
    check("midscan_oa", 32'(o_a), 32'h1F);
    #2 reset = 1'b0;
    #1 check_idle_zero("async_reset");
    @(negedge clk);
    reset = 1'b1;
    seen_finish = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (finish || busy) seen_finish++;
    end
    check("no_finish_after_abort", 32'(seen_finish), 32'h0);

    run_job(5'd5, 16'hFFFF, 16'h001F, 5'd5, 1'b0, 1'b0);
    run_job(5'd3, 16'hA0A0, 16'h20A0, 5'd3, 1'b0, 1'b1);
    run_job(5'd6, 16'h000F, 16'h000F, 5'd4, 1'b1, 1'b0);
    run_job(5'd0, 16'hFFFF, 16'h0000, 5'd0, 1'b0, 1'b0);

    // Impossible count: immediate finish+error, no scan.
    @(negedge clk);
    i_count = 5'd17;
    i_mask  = 16'hFFFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("over_finish", 32'(finish), 32'h1);
    check("over_error", 32'(error), 32'h1);
    check("over_busy", 32'(busy), 32'h0);
    check("over_oa", 32'(o_a), 32'h0);
    check("over_placed", 32'(o_placed), 32'h0);
    @(negedge clk);
    check("over_finish_drop", 32'(finish), 32'h0);
    check("over_busy_idle", 32'(busy), 32'h0);
    check("over_error_hold", 32'(error), 32'h1);

    run_job(5'd16, 16'hFFFF, 16'hFFFF, 5'd16, 1'b0, 1'b0);

    // Held start: back-to-back jobs every 17 cycles.
    @(negedge clk);
    i_count = 5'd2;
    i_mask  = 16'h8001;
    start   = 1'b1;
    @(negedge clk);
    check("b2b_first_busy", 32'(busy), 32'h1);
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 16; i++) begin
        if (i == 5) i_count = 5'd0;
        if (i == 10) i_count = 5'd2;
        @(negedge clk);
      end
      check($sformatf("b2b_finish_%0d", j), 32'(finish), 32'h1);
      check($sformatf("b2b_oa_%0d", j), 32'(o_a), 32'h8001);
      check($sformatf("b2b_placed_%0d", j), 32'(o_placed), 32'h2);
      check($sformatf("b2b_error_%0d", j), 32'(error), 32'h0);
      @(negedge clk);
      check($sformatf("b2b_restart_finish_%0d", j), 32'(finish), 32'h0);
      check($sformatf("b2b_restart_busy_%0d", j), 32'(busy), 32'h1);
      check($sformatf("b2b_restart_oa_%0d", j), 32'(o_a), 32'h0);
    end
    start = 1'b0;
    repeat (18) @(negedge clk);
    check("final_busy", 32'(busy), 32'h0);
    check("final_oa", 32'(o_a), 32'h8001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
